zbin_pt_accum: RTL and testbench

ZBIN_PT_ACCUM -- requirements
Module: zbin_pt_accum

---
 rtl/jet_zbin_pkg.sv | 8 +
 rtl/zbin_acc_cell.sv | 25 ++
 rtl/zbin_pt_accum.sv | 61 ++++++
 tb/tb_zbin_pt_accum.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/jet_zbin_pkg.sv
// jet_zbin_pkg: shared defaults, z-bin index width and FSM state type for the z-bin pT accumulator.
package jet_zbin_pkg;
    localparam int NZBIN_DEF = 6;
    localparam int PT_W_DEF  = 8;
    localparam int SUM_W_DEF = 12;
    localparam int ZW        = 4;
    typedef enum logic {ACCUM, DRAIN} state_t;
endpackage

// File: rtl/zbin_acc_cell.sv
// zbin_acc_cell: one z-bin pT sum with add, clear and wrap/saturate (saturating when ZBIN_SAT_EN is defined).
module zbin_acc_cell #(
    parameter int PT_W  = 8,
    parameter int SUM_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             add,
    input  logic             clr,
    input  logic [PT_W-1:0]  pt,
    output logic [SUM_W-1:0] sum
);
    logic [SUM_W-1:0] nxt;
`ifdef ZBIN_SAT_EN
    logic [SUM_W:0] total;
    assign total = {1'b0, sum} + (SUM_W+1)'(pt);
    assign nxt = total[SUM_W] ? '1 : total[SUM_W-1:0];
`else
    assign nxt = sum + SUM_W'(pt);
`endif
    always_ff @(posedge clk) begin
        if (reset || clr) sum <= '0;
        else if (add) sum <= nxt;
    end
endmodule

// File: rtl/zbin_pt_accum.sv
// zbin_pt_accum: accumulates track pT into z bins per event, then drains one sum word per bin.
// Build with ZBIN_SAT_EN defined for saturating sums; otherwise sums wrap.
module zbin_pt_accum
    import jet_zbin_pkg::*;
#(
    parameter int NZBIN = NZBIN_DEF,
    parameter int PT_W  = PT_W_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [PT_W-1:0]  in_pt,
    input  logic [ZW-1:0]    in_zbin1,
    input  logic [ZW-1:0]    in_zbin2,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ZW-1:0]    out_zbin,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_last,
    input  logic             out_ready
);
    state_t state;
    logic [ZW-1:0] idx;
    logic [SUM_W-1:0] sums [NZBIN];
    logic accept, take, at_end;
    assign in_ready  = state == ACCUM;
    assign out_valid = state == DRAIN;
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign at_end    = idx == ZW'(NZBIN - 1);
    assign out_zbin  = idx;
    assign out_last  = out_valid && at_end;
    // Matching both bins in one OR adds a track once when the bins coincide and skips out-of-range bins.
    for (genvar i = 0; i < NZBIN; i++) begin : g_cell
        zbin_acc_cell #(.PT_W(PT_W), .SUM_W(SUM_W)) u_cell (
            .clk  (clk),
            .reset(reset),
            .add  (accept && (in_zbin1 == ZW'(i) || in_zbin2 == ZW'(i))),
            .clr  (take && idx == ZW'(i)),
            .pt   (in_pt),
            .sum  (sums[i])
        );
    end
    always_comb begin
        out_sum = '0;
        for (int i = 0; i < NZBIN; i++) out_sum = (idx == ZW'(i)) ? sums[i] : out_sum;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
            idx   <= '0;
        end else if (state == ACCUM) begin
            if (accept && in_last) state <= DRAIN;
        end else if (out_ready) begin
            idx <= at_end ? '0 : idx + 1'b1;
            if (at_end) state <= ACCUM;
        end
    end
endmodule

// File: tb/tb_zbin_pt_accum.sv
// tb_zbin_pt_accum: directed self-checking bench for zbin_pt_accum.
module tb_zbin_pt_accum;
    logic        clk = 0;
    logic        reset = 1;
    logic        in_valid = 0;
    logic [7:0]  in_pt = 0;
    logic [3:0]  in_zbin1 = 0;
    logic [3:0]  in_zbin2 = 0;
    logic        in_last = 0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_zbin;
    logic [11:0] out_sum;
    logic        out_last;
    logic        out_ready = 1;
    int passed = 0;
    int total = 0;

    zbin_pt_accum dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pt(in_pt),
        .in_zbin1(in_zbin1), .in_zbin2(in_zbin2), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_zbin(out_zbin),
        .out_sum(out_sum), .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int pt, input int z1, input int z2, input bit last);
        in_valid = 1; in_pt = 8'(pt); in_zbin1 = 4'(z1); in_zbin2 = 4'(z2); in_last = last;
        step();
        in_valid = 0; in_last = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        step(); step();
        reset = 0;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %0b want 0", out_last); else passed++;
        total++; if (out_zbin !== 4'd0) $display("FAIL reset_out_zbin got %0d want 0", out_zbin); else passed++;
        total++; if (out_sum !== 12'd0) $display("FAIL reset_out_sum got %0d want 0", out_sum); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passed++;
    endtask

    task automatic test_basic();
        int exp [6] = '{10, 10, 0, 20, 0, 0};
        send(10, 0, 1, 0);
        send(20, 3, 3, 1);
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_zbin !== 4'(i) || out_sum !== 12'(exp[i]) || out_last !== (i == 5) || in_ready !== 1'b0)
                $display("FAIL basic_bin%0d got v=%0b z=%0d s=%0d l=%0b r=%0b want v=1 z=%0d s=%0d l=%0b r=0",
                         i, out_valid, out_zbin, out_sum, out_last, in_ready, i, exp[i], i == 5);
            else passed++;
            step();
        end
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_end got v=%0b r=%0b want v=0 r=1", out_valid, in_ready); else passed++;
    endtask

    task automatic test_out_of_range();
        int exp [6] = '{0, 0, 50, 0, 0, 0};
        send(50, 2, 15, 1);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_zbin !== 4'(i) || out_sum !== 12'(exp[i]))
                $display("FAIL oor_bin%0d got v=%0b z=%0d s=%0d want v=1 z=%0d s=%0d", i, out_valid, out_zbin, out_sum, i, exp[i]);
            else passed++;
            step();
        end
    endtask

    task automatic test_backpressure();
        int exp [6] = '{0, 7, 0, 0, 7, 0};
        send(7, 1, 4, 1);
        step();
        out_ready = 0;
        in_valid = 1; in_pt = 99; in_zbin1 = 1; in_zbin2 = 2; in_last = 1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_zbin !== 4'd1 || out_sum !== 12'd7 || in_ready !== 1'b0)
                $display("FAIL hold_cycle%0d got v=%0b z=%0d s=%0d r=%0b want v=1 z=1 s=7 r=0", c, out_valid, out_zbin, out_sum, in_ready);
            else passed++;
            step();
        end
        in_valid = 0; in_last = 0; out_ready = 1;
        for (int i = 1; i < 6; i++) begin
            total++;
            if (out_zbin !== 4'(i) || out_sum !== 12'(exp[i]) || out_last !== (i == 5))
                $display("FAIL bp_bin%0d got z=%0d s=%0d l=%0b want z=%0d s=%0d l=%0b", i, out_zbin, out_sum, out_last, i, exp[i], i == 5);
            else passed++;
            step();
        end
        send(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_zbin !== 4'(i) || out_sum !== 12'd0)
                $display("FAIL empty_bin%0d got v=%0b z=%0d s=%0d want v=1 z=%0d s=0", i, out_valid, out_zbin, out_sum, i);
            else passed++;
            step();
        end
    endtask

    task automatic test_saturate();
`ifdef ZBIN_SAT_EN
        int want = 4095;
`else
        int want = 1004;
`endif
        for (int k = 0; k < 20; k++) send(255, 0, 0, k == 19);
        total++; if (out_valid !== 1'b1 || out_sum !== 12'(want)) $display("FAIL overflow_bin0 got v=%0b s=%0d want v=1 s=%0d", out_valid, out_sum, want); else passed++;
        for (int i = 0; i < 6; i++) step();
        total++; if (out_valid !== 1'b0) $display("FAIL overflow_end got v=%0b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_drain();
        send(30, 2, 5, 1);
        step(); step();
        total++; if (out_zbin !== 4'd2 || out_sum !== 12'd30) $display("FAIL rd_at_bin2 got z=%0d s=%0d want z=2 s=30", out_zbin, out_sum); else passed++;
        reset = 1;
        step();
        reset = 0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rd_after_reset got v=%0b r=%0b want v=0 r=1", out_valid, in_ready); else passed++;
        step(); step();
        total++; if (out_valid !== 1'b0) $display("FAIL rd_idle got v=%0b want 0", out_valid); else passed++;
        send(5, 2, 2, 1);
        step(); step();
        total++; if (out_zbin !== 4'd2 || out_sum !== 12'd5) $display("FAIL rd_next_bin2 got z=%0d s=%0d want z=2 s=5", out_zbin, out_sum); else passed++;
        step(); step(); step();
        total++; if (out_zbin !== 4'd5 || out_sum !== 12'd0 || out_last !== 1'b1) $display("FAIL rd_next_bin5 got z=%0d s=%0d l=%0b want z=5 s=0 l=1", out_zbin, out_sum, out_last); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        int exp_a [6] = '{100, 0, 0, 0, 0, 101};
        int exp_b [6] = '{3, 0, 0, 0, 0, 3};
        send(100, 0, 5, 0);
        send(1, 5, 5, 1);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_sum !== 12'(exp_a[i]) || in_ready !== 1'b0)
                $display("FAIL b2b_a_bin%0d got s=%0d r=%0b want s=%0d r=0", i, out_sum, in_ready, exp_a[i]);
            else passed++;
            step();
        end
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got %0b want 1", in_ready); else passed++;
        send(3, 5, 0, 1);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_sum !== 12'(exp_b[i]) || in_ready !== 1'b0)
                $display("FAIL b2b_b_bin%0d got s=%0d r=%0b want s=%0d r=0", i, out_sum, in_ready, exp_b[i]);
            else passed++;
            step();
        end
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_end got r=%0b v=%0b want r=1 v=0", in_ready, out_valid); else passed++;
    endtask

    initial begin
        step();
        test_reset();
        test_basic();
        test_out_of_range();
        test_backpressure();
        test_saturate();
        test_reset_drain();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
